servo_ramp: RTL and testbench

SERVO_RAMP -- requirements
Module: servo_ramp

---
 rtl/servo_ramp.sv | 147 ++++++++++++++
 tb/tb_servo_ramp.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_ramp.sv
// Servo pulse-width ramp: converts an angle command into a PWM high-time and slews toward it
// by at most STEP ticks every HOLD_FRAMES PWM frames. Optional build macro SERVO_RAMP_PREEMPT_EN.
module servo_ramp #(
   parameter int unsigned MIN_W       = 25000,
   parameter int unsigned MAX_W       = 50000,
   parameter int unsigned STEP        = 250,
   parameter int unsigned HOLD_FRAMES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_angle,
   input  logic        frame_start,
   output logic [19:0] pulse_width,
   output logic        busy,
   output logic        dir_up
);

   localparam logic [19:0] MIN_V     = 20'(MIN_W);
   localparam logic [19:0] MAX_V     = 20'(MAX_W);
   localparam logic [19:0] STEP_V    = 20'(STEP);
   localparam logic [7:0]  HOLD_LAST = 8'(HOLD_FRAMES - 1);
   localparam logic [7:0]  ANGLE_MAX = 8'd180;

`ifdef SERVO_RAMP_PREEMPT_EN
   localparam bit PREEMPT_EN = 1'b1;
`else
   localparam bit PREEMPT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      IDLE,
      CONVERT,
      MOVE
   } state_t;

   state_t      state, state_next;
   logic [7:0]  angle_q, angle_next;
   logic [19:0] target, target_next;
   logic [19:0] pw_next;
   logic [7:0]  divider, divider_next;
   logic        dir_next;
   logic        ready_next;
   logic        busy_next;

   logic        accept;
   logic [7:0]  angle_clamped;
   logic [21:0] product;
   logic [19:0] target_raw;
   logic [19:0] target_calc;
   logic [19:0] up_gap;
   logic [19:0] down_gap;
   logic [19:0] stepped;

   assign accept        = cmd_valid & cmd_ready;
   assign angle_clamped = (cmd_angle > ANGLE_MAX) ? ANGLE_MAX : cmd_angle;

   // 180 * 8889 needs 21 bits; the >> 6 turns degrees into ticks with ~0.002% error.
   assign product     = 22'(angle_q) * 22'd8889;
   assign target_raw  = MIN_V + 20'(product >> 6);
   assign target_calc = (target_raw > MAX_V) ? MAX_V : target_raw;

   // Only the gap in the direction of travel is meaningful, so neither subtraction wraps in use.
   assign up_gap   = target - pulse_width;
   assign down_gap = pulse_width - target;

   always_comb begin
      if (target > pulse_width)
         stepped = (up_gap <= STEP_V) ? target : pulse_width + STEP_V;
      else
         stepped = (down_gap <= STEP_V) ? target : pulse_width - STEP_V;
   end

   always_comb begin
      // NOTE: every output of this block gets a default first so no path can infer a latch.
      state_next   = state;
      angle_next   = angle_q;
      target_next  = target;
      pw_next      = pulse_width;
      divider_next = divider;
      dir_next     = dir_up;

      case (state)
         IDLE: begin
            if (accept) begin
               angle_next = angle_clamped;
               state_next = CONVERT;
            end
         end

         CONVERT: begin
            target_next  = target_calc;
            divider_next = '0;
            dir_next     = (target_calc > pulse_width);
            state_next   = MOVE;
         end

         MOVE: begin
            if (PREEMPT_EN && accept) begin
               angle_next   = angle_clamped;
               divider_next = '0;
               state_next   = CONVERT;
            end else if (pulse_width == target) begin
               state_next = IDLE;
            end else if (frame_start) begin
               // The update lands on the same edge as the frame pulse, ahead of the PWM compare.
               if (divider == HOLD_LAST) begin
                  divider_next = '0;
                  pw_next      = stepped;
               end else begin
                  divider_next = divider + 8'd1;
               end
            end
         end

         default: state_next = IDLE;
      endcase

      ready_next = (state_next == IDLE) || (PREEMPT_EN && (state_next == MOVE));
      busy_next  = (state_next != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         state       <= IDLE;
         angle_q     <= '0;
         target      <= MIN_V;
         pulse_width <= MIN_V;
         divider     <= '0;
         cmd_ready   <= 1'b0;
         busy        <= 1'b0;
         dir_up      <= 1'b1;
      end else begin
         state       <= state_next;
         angle_q     <= angle_next;
         target      <= target_next;
         pulse_width <= pw_next;
         divider     <= divider_next;
         cmd_ready   <= ready_next;
         busy        <= busy_next;
         dir_up      <= dir_next;
      end
   end

endmodule

// File: tb/tb_servo_ramp.sv
// Self-checking bench for servo_ramp: directed ramps plus random angle/frame-spacing moves
// compared against an arithmetic position model. Honors SERVO_RAMP_PREEMPT_EN when defined.
module tb_servo_ramp;

   localparam int MIN_W = 25000;
   localparam int MAX_W = 50000;
   localparam int STEP  = 250;
   localparam int HOLD  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_angle;
   logic        frame_start;
   logic [19:0] pulse_width;
   logic        busy;
   logic        dir_up;

   int checks = 0;
   int errors = 0;

   int model_pw;
   int model_tgt;
   int frame_cnt;
   int updates;
   bit exp_dir;

   always #20 clk = ~clk;

   servo_ramp #(
      .MIN_W       (MIN_W),
      .MAX_W       (MAX_W),
      .STEP        (STEP),
      .HOLD_FRAMES (HOLD)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cmd_valid   (cmd_valid),
      .cmd_ready   (cmd_ready),
      .cmd_angle   (cmd_angle),
      .frame_start (frame_start),
      .pulse_width (pulse_width),
      .busy        (busy),
      .dir_up      (dir_up)
   );

   // Degrees to ticks, with out-of-range commands pinned at 180.
   function automatic int tgt_of(input int angle);
      int a;
      a = (angle > 180) ? 180 : angle;
      return MIN_W + (a * 8889) / 64;
   endfunction

   function automatic int step_toward(input int pw, input int tgt);
      int d;
      d = tgt - pw;
      if (d > STEP)  return pw + STEP;
      if (d < -STEP) return pw - STEP;
      return tgt;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic send_cmd(input int angle);
      int waited = 0;
      while (cmd_ready !== 1'b1 && waited < 50) begin
         @(negedge clk);
         waited++;
      end
      check("cmd_ready_wait", cmd_ready, 1);
      cmd_valid = 1'b1;
      cmd_angle = 8'(angle);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   // Handshake, pass through CONVERT (optionally with a frame pulse that must be ignored), enter MOVE.
   task automatic start_move(input int angle, input bit frame_in_convert);
      send_cmd(angle);
      model_tgt = tgt_of(angle);
      exp_dir   = (model_tgt > model_pw);
      frame_cnt = 0;
      updates   = 0;
      check("busy_convert", busy, 1);
      check("ready_convert", cmd_ready, 0);
      frame_start = frame_in_convert;
      @(negedge clk);
      frame_start = 1'b0;
      check("dir_up_entry", dir_up, exp_dir);
      check("busy_move", busy, 1);
      check("pw_entry", pulse_width, model_pw);
   endtask

   task automatic do_frame(input int gap);
      frame_start = 1'b1;
      @(negedge clk);
      frame_start = 1'b0;
      frame_cnt++;
      if (frame_cnt % HOLD == 0) begin
         model_pw = step_toward(model_pw, model_tgt);
         updates++;
      end
      check("pulse_width", pulse_width, model_pw);
      check("pw_in_range", (pulse_width >= MIN_W) && (pulse_width <= MAX_W), 1);
      check("busy_ramp", busy, 1);
      if (model_pw == model_tgt) begin
         @(negedge clk);
         check("busy_done", busy, 0);
         check("ready_done", cmd_ready, 1);
         check("dir_up_held", dir_up, exp_dir);
         for (int i = 0; i < gap - 2; i++) @(negedge clk);
      end else begin
         for (int i = 0; i < gap - 1; i++) @(negedge clk);
      end
   endtask

   task automatic finish_move(input int gap);
      int guard = 0;
      if (model_pw == model_tgt) begin
         @(negedge clk);
         check("busy_done_nomove", busy, 0);
         check("ready_done_nomove", cmd_ready, 1);
      end
      while (model_pw != model_tgt && guard < 1000) begin
         do_frame(gap);
         guard++;
      end
      check("ramp_bounded", guard < 1000, 1);
      check("final_pw", pulse_width, model_tgt);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      int g;
      rst_n       = 1'b0;
      cmd_valid   = 1'b0;
      cmd_angle   = '0;
      frame_start = 1'b0;
      model_pw    = MIN_W;
      model_tgt   = MIN_W;

      // Reset held for three cycles, then released.
      repeat (3) @(negedge clk);
      check("rst_pw", pulse_width, MIN_W);
      check("rst_busy", busy, 0);
      check("rst_dir_up", dir_up, 1);
      check("rst_ready", cmd_ready, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_release", cmd_ready, 1);
      check("pw_after_release", pulse_width, MIN_W);

      // Full sweep 0 -> 180.
      start_move(180, 1'b1);
      finish_move(10);
      check("sweep_updates", updates, 100);
      check("sweep_frames", frame_cnt, 200);
      check("sweep_final", pulse_width, 50000);

      // Down to 90, then a partial step to 91.
      start_move(90, 1'b0);
      check("dir_down", dir_up, 0);
      finish_move(10);
      check("down_updates", updates, 50);
      check("down_final", pulse_width, 37500);
      start_move(91, 1'b0);
      finish_move(7);
      check("partial_updates", updates, 1);
      check("partial_final", pulse_width, tgt_of(91));

      // Over-range angle clamps; a command at the current position completes without frames.
      start_move(200, 1'b0);
      finish_move(5);
      check("clamp_final", pulse_width, 50000);
      start_move(180, 1'b0);
      finish_move(10);
      check("same_pos_updates", updates, 0);

      // Command arriving mid-ramp toward 180.
      start_move(0, 1'b0);
      finish_move(3);
      start_move(180, 1'b0);
      repeat (20) do_frame(10);
      cmd_valid = 1'b1;
      cmd_angle = 8'd0;
`ifdef SERVO_RAMP_PREEMPT_EN
      check("preempt_ready", cmd_ready, 1);
      @(negedge clk);
      cmd_valid = 1'b0;
      check("preempt_busy", busy, 1);
      check("preempt_pw_kept", pulse_width, model_pw);
      model_tgt = MIN_W;
      exp_dir   = 1'b0;
      frame_cnt = 0;
      updates   = 0;
      @(negedge clk);
      check("preempt_dir", dir_up, 0);
      finish_move(10);
      check("preempt_final", pulse_width, 25000);
`else
      for (int i = 0; i < 3; i++) begin
         check("no_preempt_ready", cmd_ready, 0);
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      check("no_preempt_pw", pulse_width, model_pw);
      finish_move(10);
      check("no_preempt_final", pulse_width, 50000);
`endif

      // Reset in the middle of a ramp at 40000.
      start_move(0, 1'b0);
      finish_move(2);
      start_move(180, 1'b0);
      for (int i = 0; i < 200 && model_pw != 40000; i++) do_frame(4);
      check("mid_ramp_pw", pulse_width, 40000);
      rst_n = 1'b0;
      @(negedge clk);
      check("abort_pw", pulse_width, MIN_W);
      check("abort_busy", busy, 0);
      check("abort_dir", dir_up, 1);
      check("abort_ready", cmd_ready, 0);
      rst_n    = 1'b1;
      model_pw = MIN_W;
      @(negedge clk);
      check("abort_ready_back", cmd_ready, 1);
      for (int i = 0; i < 6; i++) begin
         frame_start = 1'b1;
         @(negedge clk);
         frame_start = 1'b0;
         @(negedge clk);
         check("idle_no_motion", pulse_width, MIN_W);
         check("idle_not_busy", busy, 0);
      end

      // Random angles (some over-range) with random frame spacing.
      for (int n = 0; n < 8; n++) begin
         a = int'($urandom_range(0, 255));
         g = int'($urandom_range(2, 12));
         start_move(a, 1'($urandom_range(0, 1)));
         finish_move(g);
         check("rand_final", pulse_width, tgt_of(a));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
